// File: rtl/aclk_tick_gen_if.sv
// Control and strobe bundle between the alarm-clock time base and its consumers.
// The master side drives the controls; the slave side (the tick generator) returns strobes and counts.
interface aclk_tick_gen_if #(
    parameter int SEC_PER_MIN = 60,
    parameter int MIN_PER_HR  = 60
);
    localparam int SW = $clog2(SEC_PER_MIN);
    localparam int MW = $clog2(MIN_PER_HR);

    logic          reset_count;
    logic          count_en;
    logic          fast_watch;
    logic          one_second;
    logic          one_minute;
    logic          one_hour;
    logic [SW-1:0] sec_count;
    logic [MW-1:0] min_count;

    modport master (
        output reset_count, count_en, fast_watch,
        input  one_second, one_minute, one_hour, sec_count, min_count
    );

    modport slave (
        input  reset_count, count_en, fast_watch,
        output one_second, one_minute, one_hour, sec_count, min_count
    );
endinterface

// File: rtl/aclk_tick_gen.sv
// Alarm-clock time base: registered one_second/one_minute/one_hour strobes plus second/minute counts.
// Define ACLK_TICK_GEN_HOUR_EN to generate the hour strobe; otherwise one_hour is tied low.
module aclk_tick_gen #(
    parameter int CLK_PER_SEC      = 256,
    parameter int SEC_PER_MIN      = 60,
    parameter int MIN_PER_HR       = 60,
    parameter int FAST_CLK_PER_MIN = 256
) (
    input  logic clk,
    input  logic reset,
    aclk_tick_gen_if.slave bus
);
    localparam int PMAX = (CLK_PER_SEC > FAST_CLK_PER_MIN) ? CLK_PER_SEC : FAST_CLK_PER_MIN;
    localparam int PW   = $clog2(PMAX);
    localparam int SW   = $clog2(SEC_PER_MIN);
    localparam int MW   = $clog2(MIN_PER_HR);

    localparam logic [PW-1:0] PRE_SEC_LAST  = PW'(CLK_PER_SEC - 1);
    localparam logic [PW-1:0] PRE_FAST_LAST = PW'(FAST_CLK_PER_MIN - 1);
    localparam logic [SW-1:0] SEC_LAST      = SW'(SEC_PER_MIN - 1);
    localparam logic [MW-1:0] MIN_LAST      = MW'(MIN_PER_HR - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [MW-1:0] min_q, min_d;
    logic          fast_q, fast_d;
    logic          sec_stb_q, sec_stb_d;
    logic          min_stb_q, min_stb_d;
    logic          min_tick;
`ifdef ACLK_TICK_GEN_HOUR_EN
    logic          hr_stb_q, hr_stb_d;
`endif

    always_comb begin
        pre_d     = pre_q;
        sec_d     = sec_q;
        min_d     = min_q;
        fast_d    = fast_q;
        sec_stb_d = 1'b0;
        min_stb_d = 1'b0;
        min_tick  = 1'b0;
`ifdef ACLK_TICK_GEN_HOUR_EN
        hr_stb_d  = 1'b0;
`endif
        if (bus.reset_count) begin
            pre_d  = '0;
            sec_d  = '0;
            min_d  = '0;
            fast_d = bus.fast_watch;
        end else if (bus.fast_watch != fast_q) begin
            // Rate switch restarts the current second/minute but keeps the minute count.
            pre_d  = '0;
            sec_d  = '0;
            fast_d = bus.fast_watch;
        end else if (bus.count_en) begin
            if (!fast_q) begin
                if (pre_q == PRE_SEC_LAST) begin
                    pre_d     = '0;
                    sec_stb_d = 1'b1;
                    if (sec_q == SEC_LAST) begin
                        sec_d    = '0;
                        min_tick = 1'b1;
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end else begin
                // Fast mode: the prescaler counts straight to minutes, seconds stay parked at 0.
                if (pre_q == PRE_FAST_LAST) begin
                    pre_d    = '0;
                    min_tick = 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end

            if (min_tick) begin
                min_stb_d = 1'b1;
                if (min_q == MIN_LAST) begin
                    min_d = '0;
`ifdef ACLK_TICK_GEN_HOUR_EN
                    hr_stb_d = 1'b1;
`endif
                end else begin
                    min_d = min_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q     <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            fast_q    <= 1'b0;
            sec_stb_q <= 1'b0;
            min_stb_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            fast_q    <= fast_d;
            sec_stb_q <= sec_stb_d;
            min_stb_q <= min_stb_d;
        end
    end

`ifdef ACLK_TICK_GEN_HOUR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hr_stb_q <= 1'b0;
        else       hr_stb_q <= hr_stb_d;
    end
    assign bus.one_hour = hr_stb_q;
`else
    assign bus.one_hour = 1'b0;
`endif

    assign bus.one_second = sec_stb_q;
    assign bus.one_minute = min_stb_q;
    assign bus.sec_count  = sec_q;
    assign bus.min_count  = min_q;
endmodule

// File: tb/tb_aclk_tick_gen.sv
// Scoreboard bench for aclk_tick_gen: stimulus pushes model expectations, a monitor pops and compares.
module tb_aclk_tick_gen;
    localparam int CPS  = 4;
    localparam int SPM  = 3;
    localparam int MPH  = 2;
    localparam int FCPM = 8;

    typedef struct {
        bit s;
        bit m;
        bit h;
        int sc;
        int mc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    // model state: counters as plain integers
    int m_pre = 0, m_sec = 0, m_min = 0;
    bit m_fq = 0;

    aclk_tick_gen_if #(.SEC_PER_MIN(SPM), .MIN_PER_HR(MPH)) bus ();

    aclk_tick_gen #(
        .CLK_PER_SEC(CPS), .SEC_PER_MIN(SPM), .MIN_PER_HR(MPH), .FAST_CLK_PER_MIN(FCPM)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; the expected output after the coming edge is queued.
    task automatic step(input bit rst_v, input bit rc, input bit en, input bit fw);
        exp_t e;
        @(negedge clk);
        #1;
        bus.reset_count = rc;
        bus.count_en    = en;
        bus.fast_watch  = fw;
        reset           = rst_v;
        e = '{s: 0, m: 0, h: 0, sc: 0, mc: 0};
        if (rst_v) begin
            m_pre = 0; m_sec = 0; m_min = 0; m_fq = 0;
        end else if (rc) begin
            m_pre = 0; m_sec = 0; m_min = 0; m_fq = fw;
        end else if (fw != m_fq) begin
            m_pre = 0; m_sec = 0; m_fq = fw;
        end else if (en) begin
            bit minute = 0;
            m_pre = m_pre + 1;
            if (!m_fq && m_pre == CPS) begin
                m_pre = 0;
                e.s = 1;
                m_sec = (m_sec + 1) % SPM;
                minute = (m_sec == 0);
            end else if (m_fq && m_pre == FCPM) begin
                m_pre = 0;
                minute = 1;
            end
            if (minute) begin
                e.m = 1;
                m_min = (m_min + 1) % MPH;
`ifdef ACLK_TICK_GEN_HOUR_EN
                e.h = (m_min == 0);
`endif
            end
        end
        e.sc = m_sec;
        e.mc = m_min;
        q.push_back(e);
        if (rst_v) begin
            #1;
            total++;
            if (bus.one_second !== 1'b0 || bus.one_minute !== 1'b0 || bus.one_hour !== 1'b0 ||
                bus.sec_count !== '0 || bus.min_count !== '0) begin
                bad++;
                $display("FAIL async_reset t=%0t got s=%b m=%b h=%b sc=%0d mc=%0d want all zero",
                         $time, bus.one_second, bus.one_minute, bus.one_hour,
                         bus.sec_count, bus.min_count);
            end
        end
    endtask

    // monitor: one expectation per clock edge, compared away from the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (bus.one_second !== e.s || bus.one_minute !== e.m || bus.one_hour !== e.h ||
                    int'(bus.sec_count) != e.sc || int'(bus.min_count) != e.mc) begin
                    bad++;
                    $display("FAIL outputs t=%0t got s=%b m=%b h=%b sc=%0d mc=%0d want s=%b m=%b h=%b sc=%0d mc=%0d",
                             $time, bus.one_second, bus.one_minute, bus.one_hour,
                             bus.sec_count, bus.min_count, e.s, e.m, e.h, e.sc, e.mc);
                end
            end
        end
    end

    initial begin
        bus.reset_count = 1'b0;
        bus.count_en    = 1'b1;
        bus.fast_watch  = 1'b0;
        #1;
        total++;
        if (bus.one_second !== 1'b0 || bus.one_minute !== 1'b0 || bus.sec_count !== '0) begin
            bad++;
            $display("FAIL reset_state got s=%b m=%b sc=%0d want 0", bus.one_second,
                     bus.one_minute, bus.sec_count);
        end

        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        // normal counting across seconds, minutes and an hour wrap
        for (int i = 0; i < 30; i++) step(0, 0, 1, 0);
        // hold mid-second
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        // switch to fast mode with pre=2, sec=1
        for (int i = 0; i < 40 && !(m_pre == 2 && m_sec == 1); i++) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 30; i++) step(0, 0, 1, 1);
        // reset_count on the terminal edge, fast then normal
        for (int i = 0; i < 20 && m_pre != FCPM - 1; i++) step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 20 && m_pre != CPS - 1; i++) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        // fast mode straight from reset
        step(1, 0, 1, 1);
        for (int i = 0; i < 40; i++) step(0, 0, 1, 1);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            bit fw_r;
            fw_r = ($urandom_range(0, 49) == 0) ? ~bus.fast_watch : bus.fast_watch;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) != 0, fw_r);
        end
        // async reset asserted mid-count, then release and resume
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);

        @(negedge clk);
        @(negedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
